// File: rtl/time_pkg.sv
// Shared constants and types for the time keeper: counter limits,
// BCD digit width, and a helper that encodes a limit as a BCD pair.
package time_pkg;

  localparam int BCD_WIDTH   = 4;
  localparam int SECONDS_MAX = 59;
  localparam int MINUTES_MAX = 59;
  localparam int HOURS_MAX   = 23;

  typedef logic [BCD_WIDTH-1:0] bcdDigit_t;

  typedef struct packed {
    bcdDigit_t tens;
    bcdDigit_t ones;
  } bcdPair_t;

  // Split a small binary value (0..99) into its BCD tens and ones digits.
  function automatic bcdPair_t toBcdPair(input int value);
    bcdPair_t pair;
    pair.tens = BCD_WIDTH'(value / 10);
    pair.ones = BCD_WIDTH'(value % 10);
    return pair;
  endfunction

endpackage

// File: rtl/bcd_modulo_counter.sv
// Two-digit BCD counter that wraps from 'maximum' back to 00.
// 'carry' is high in the cycle an increment wraps the counter.
module bcd_modulo_counter
  import time_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      increment,
  input  bcdPair_t  maximum,
  output bcdDigit_t tens,
  output bcdDigit_t ones,
  output logic      carry
);

  localparam bcdDigit_t DIGIT_NINE = BCD_WIDTH'(9);

  logic atMaximum;

  // Wrap detection: compare both digits against the programmed limit.
  always_comb begin
    atMaximum = (tens == maximum.tens) && (ones == maximum.ones);
    carry     = increment && atMaximum;
  end

  // Digit update: ones roll 9->0 into tens; the whole pair wraps at maximum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tens <= '0;
      ones <= '0;
    end else if (increment) begin
      if (atMaximum) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == DIGIT_NINE) begin
        tens <= tens + BCD_WIDTH'(1);
        ones <= '0;
      end else begin
        ones <= ones + BCD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour clock: a prescaler turns TICKS_PER_SECOND clock cycles into one
// second tick, seconds carry into BCD minutes, minutes carry into BCD hours.
// Manual increment pulses set the time; every output is a register.
module time_keeper
  import time_pkg::*;
#(
  parameter int TICKS_PER_SECOND = 100000000
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      run,
  input  logic      incrementHour,
  input  logic      incrementMinute,
  output bcdDigit_t nibbleA,
  output bcdDigit_t nibbleB,
  output bcdDigit_t nibbleC,
  output bcdDigit_t nibbleD,
  output logic      secondPulse,
  output logic      colon
);

  localparam int PRESCALE_WIDTH = $clog2(TICKS_PER_SECOND);
  localparam int SECONDS_WIDTH  = 6;

  typedef logic [PRESCALE_WIDTH-1:0] prescale_t;
  typedef logic [SECONDS_WIDTH-1:0]  seconds_t;

  localparam prescale_t PRESCALE_LAST = PRESCALE_WIDTH'(TICKS_PER_SECOND - 1);
  localparam prescale_t PRESCALE_HALF = PRESCALE_WIDTH'(TICKS_PER_SECOND / 2);
  localparam seconds_t  SECONDS_LAST  = SECONDS_WIDTH'(SECONDS_MAX);
  localparam bcdPair_t  MINUTES_LIMIT = toBcdPair(MINUTES_MAX);
  localparam bcdPair_t  HOURS_LIMIT   = toBcdPair(HOURS_MAX);

  prescale_t prescaler;
  prescale_t prescalerNext;
  seconds_t  seconds;
  logic      secondTick;
  logic      secondsCarry;
  logic      minuteIncrement;
  logic      minuteCarry;
  logic      hourIncrement;
  logic      hourCarry;

  // Tick and carry chain. A manual minute step wins over a same-cycle tick:
  // the tick's carries are dropped, and a manual hour step absorbs any
  // tick-generated hour carry so hours never move by more than one.
  always_comb begin
    secondTick      = run && (prescaler == PRESCALE_LAST);
    secondsCarry    = secondTick && (seconds == SECONDS_LAST);
    minuteIncrement = incrementMinute || secondsCarry;
    hourIncrement   = incrementHour || (minuteCarry && !incrementMinute);
  end

  // Next prescaler value: cleared by a minute step, frozen while not running.
  always_comb begin
    prescalerNext = prescaler;
    if (incrementMinute) begin
      prescalerNext = '0;
    end else if (run) begin
      prescalerNext = secondTick ? '0 : prescaler + PRESCALE_WIDTH'(1);
    end
  end

  // Prescaler, second pulse and colon blink registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      secondPulse <= 1'b0;
      colon       <= 1'b0;
    end else begin
      prescaler   <= prescalerNext;
      secondPulse <= secondTick;
      colon       <= (prescalerNext < PRESCALE_HALF);
    end
  end

  // Seconds 0..59: cleared by a minute step, otherwise advanced by the tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seconds <= '0;
    end else if (incrementMinute) begin
      seconds <= '0;
    end else if (secondTick) begin
      seconds <= secondsCarry ? '0 : seconds + SECONDS_WIDTH'(1);
    end
  end

  bcd_modulo_counter minuteCounter (
    .clock     (clock),
    .reset     (reset),
    .increment (minuteIncrement),
    .maximum   (MINUTES_LIMIT),
    .tens      (nibbleC),
    .ones      (nibbleD),
    .carry     (minuteCarry)
  );

  bcd_modulo_counter hourCounter (
    .clock     (clock),
    .reset     (reset),
    .increment (hourIncrement),
    .maximum   (HOURS_LIMIT),
    .tens      (nibbleA),
    .ones      (nibbleB),
    .carry     (hourCarry)
  );

  // Hours wrap 23 -> 00 with nothing above them; the carry is intentionally unused.
  logic unusedHourCarry;
  assign unusedHourCarry = hourCarry;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with a small prescale so whole
// minutes and day rollovers fit in a short run.
module tb_time_keeper;

  localparam int TPS = 4;

  logic       clock;
  logic       reset;
  logic       run;
  logic       incrementHour;
  logic       incrementMinute;
  logic [3:0] nibbleA;
  logic [3:0] nibbleB;
  logic [3:0] nibbleC;
  logic [3:0] nibbleD;
  logic       secondPulse;
  logic       colon;

  int vectorCount = 0;
  int failCount   = 0;
  int pulseCount  = 0;

  // Reference state: time of day as plain integers.
  int refHour  = 0;
  int refMin   = 0;
  int refSec   = 0;
  int refPre   = 0;
  int refPulse = 0;
  int refColon = 0;

  time_keeper #(.TICKS_PER_SECOND(TPS)) dut (
    .clock           (clock),
    .reset           (reset),
    .run             (run),
    .incrementHour   (incrementHour),
    .incrementMinute (incrementMinute),
    .nibbleA         (nibbleA),
    .nibbleB         (nibbleB),
    .nibbleC         (nibbleC),
    .nibbleD         (nibbleD),
    .secondPulse     (secondPulse),
    .colon           (colon)
  );

  // Clock generation.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkValue(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed != expected) begin
      failCount++;
      $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutputs(input string tag);
    checkValue({tag, "_a"}, int'(nibbleA), refHour / 10);
    checkValue({tag, "_b"}, int'(nibbleB), refHour % 10);
    checkValue({tag, "_c"}, int'(nibbleC), refMin / 10);
    checkValue({tag, "_d"}, int'(nibbleD), refMin % 10);
    checkValue({tag, "_pulse"}, int'(secondPulse), refPulse);
    checkValue({tag, "_colon"}, int'(colon), refColon);
  endtask

  task automatic modelReset();
    refHour = 0; refMin = 0; refSec = 0; refPre = 0; refPulse = 0; refColon = 0;
  endtask

  // Time-of-day rules applied for one rising edge.
  task automatic modelEdge(input bit r, input bit h, input bit m);
    bit tick;
    bit hourCarry;
    tick      = r && (refPre == TPS - 1);
    hourCarry = 0;
    refPulse  = tick;
    if (m) begin
      refMin = (refMin + 1) % 60;
      refSec = 0;
      refPre = 0;
    end else begin
      if (r) refPre = (refPre + 1) % TPS;
      if (tick) begin
        refSec++;
        if (refSec == 60) begin
          refSec = 0;
          refMin++;
          if (refMin == 60) begin
            refMin    = 0;
            hourCarry = 1;
          end
        end
      end
    end
    if (h || hourCarry) refHour = (refHour + 1) % 24;
    refColon = (refPre < TPS / 2);
  endtask

  // One clock cycle with the given inputs, then compare against the model.
  task automatic step(input bit r, input bit h, input bit m, input string tag);
    run = r; incrementHour = h; incrementMinute = m;
    @(posedge clock);
    modelEdge(r, h, m);
    #1;
    if (secondPulse) pulseCount++;
    checkOutputs(tag);
    incrementHour = 1'b0; incrementMinute = 1'b0;
  endtask

  // Asynchronous reset pulse asserted between edges; outputs checked before any edge.
  task automatic asyncReset(input string tag);
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkOutputs(tag);
    @(posedge clock);
    #1 reset = 1'b0;
    incrementHour = 1'b0; incrementMinute = 1'b0;
  endtask

  task automatic setHours(input int target);
    while (refHour != target) step(1'b0, 1'b1, 1'b0, "set_hour");
  endtask

  task automatic setMinutes(input int target);
    while (refMin != target) step(1'b0, 1'b0, 1'b1, "set_min");
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; incrementHour = 1'b0; incrementMinute = 1'b0;
    modelReset();
    #1;
    checkOutputs("reset_async");
    @(posedge clock);
    #1 reset = 1'b0;

    // One full minute of seconds from reset.
    pulseCount = 0;
    for (int i = 0; i < 240; i++) step(1'b1, 1'b0, 1'b0, "run240");
    checkValue("run240_pulses", pulseCount, 60);
    checkValue("run240_d", int'(nibbleD), 1);
    checkValue("run240_c", int'(nibbleC), 0);

    // Day rollover from 23:59:59 with the prescaler at its last count.
    setHours(23);
    setMinutes(59);
    for (int i = 0; i < 59 * TPS + TPS - 1; i++) step(1'b1, 1'b0, 1'b0, "pre_roll");
    step(1'b1, 1'b0, 1'b0, "roll");
    checkValue("roll_a", int'(nibbleA), 0);
    checkValue("roll_b", int'(nibbleB), 0);
    checkValue("roll_c", int'(nibbleC), 0);
    checkValue("roll_d", int'(nibbleD), 0);
    checkValue("roll_pulse", int'(secondPulse), 1);

    // Minute step wraps 59 -> 00 without touching hours, and clears seconds.
    setHours(14);
    setMinutes(59);
    for (int i = 0; i < 2 * TPS + 1; i++) step(1'b1, 1'b0, 1'b0, "mid_min");
    step(1'b1, 1'b0, 1'b1, "min_wrap");
    checkValue("min_wrap_a", int'(nibbleA), 1);
    checkValue("min_wrap_b", int'(nibbleB), 4);
    checkValue("min_wrap_c", int'(nibbleC), 0);
    checkValue("min_wrap_d", int'(nibbleD), 0);
    for (int i = 0; i < 60 * TPS - 1; i++) step(1'b1, 1'b0, 1'b0, "sec_cleared");
    checkValue("sec_cleared_d", int'(nibbleD), 0);
    step(1'b1, 1'b0, 1'b0, "sec_cleared_last");
    checkValue("sec_cleared_next_d", int'(nibbleD), 1);

    // Hour step wraps 23 -> 00; hour step coinciding with a tick carry.
    setHours(23);
    step(1'b0, 1'b1, 1'b0, "hour_wrap");
    checkValue("hour_wrap_a", int'(nibbleA), 0);
    checkValue("hour_wrap_b", int'(nibbleB), 0);
    setHours(12);
    setMinutes(59);
    for (int i = 0; i < 59 * TPS + TPS - 1; i++) step(1'b1, 1'b0, 1'b0, "pre_carry");
    step(1'b1, 1'b1, 1'b0, "carry_hour");
    checkValue("carry_hour_a", int'(nibbleA), 1);
    checkValue("carry_hour_b", int'(nibbleB), 3);
    checkValue("carry_hour_c", int'(nibbleC), 0);
    checkValue("carry_hour_d", int'(nibbleD), 0);

    // Frozen time; manual hour steps still work.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "pre_freeze");
    pulseCount = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, "freeze");
    checkValue("freeze_pulses", pulseCount, 0);
    step(1'b0, 1'b1, 1'b0, "freeze_hour");
    checkValue("freeze_hour_b", int'(nibbleB), 4);

    // Reset mid-second at 10:30, and reset during an increment pulse.
    setHours(10);
    setMinutes(30);
    step(1'b1, 1'b0, 1'b0, "mid_sec");
    step(1'b1, 1'b0, 1'b0, "mid_sec");
    asyncReset("reset_mid");
    checkValue("reset_mid_a", int'(nibbleA), 0);
    setHours(5);
    incrementHour = 1'b1; incrementMinute = 1'b1;
    asyncReset("reset_pulse");
    pulseCount = 0;
    for (int i = 0; i < TPS; i++) step(1'b1, 1'b0, 1'b0, "after_reset");
    checkValue("first_pulse", pulseCount, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        asyncReset("rand_reset");
      end else begin
        step(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 15) == 0), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SECOND, default 100000000, meaning clock cycles per real-time second (minimum 4, even).
REQ-002 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  high lets time advance; low freezes the prescaler and seconds.
REQ-005 SHALL have port incrementHour  input  1  single-cycle pulse that advances hours by one.
REQ-006 SHALL have port incrementMinute  input  1  single-cycle pulse that advances minutes by one.
REQ-007 SHALL have port nibbleA  output  4  hour tens digit, BCD.
REQ-008 SHALL have port nibbleB  output  4  hour ones digit, BCD.
REQ-009 SHALL have port nibbleC  output  4  minute tens digit, BCD.
REQ-010 SHALL have port nibbleD  output  4  minute ones digit, BCD.
REQ-011 SHALL have port secondPulse  output  1  one-cycle pulse per elapsed second.
REQ-012 SHALL have port colon  output  1  blink signal for the display separator.

Function
REQ-013 SHALL keep a prescaler counting 0..TICKS_PER_SECOND-1 while run=1, wrapping to 0; it holds its value while run=0.
REQ-014 SHALL raise secondPulse for exactly the cycle after the prescaler reaches TICKS_PER_SECOND-1, so the pulse is registered with 1 cycle latency.
REQ-015 SHALL keep seconds 0..59; each second tick increments them; 59 wraps to 0 and carries into minutes.
REQ-016 SHALL keep minutes as two BCD digits 00..59; a seconds carry increments them; 59 wraps to 00 and carries into hours.
REQ-017 SHALL keep hours as two BCD digits 00..23; a minute carry increments them; 23 wraps to 00 with no further carry.
REQ-018 SHALL roll 23:59:59 to 00:00:00 on a single tick.
REQ-019 SHALL advance minutes by exactly 1 (mod 60) on incrementMinute, with no carry into hours, and SHALL clear the seconds and the prescaler in the same cycle.
REQ-020 SHALL advance hours by exactly 1 (mod 24) on incrementHour, with no carry, and SHALL leave minutes, seconds and the prescaler untouched.
REQ-021 SHALL honour incrementHour and incrementMinute regardless of run.
REQ-022 SHALL give incrementMinute priority over a same-cycle second tick: the tick and any carries from it are discarded, and secondPulse still fires.
REQ-023 SHALL, when incrementHour coincides with a tick-generated hour carry, advance hours by exactly 1 (the carry is discarded).
REQ-024 SHALL, when both increment inputs are high in one cycle, apply both as REQ-019 and REQ-020 describe.
REQ-025 SHALL drive colon high while the prescaler is below TICKS_PER_SECOND/2 and low otherwise, registered.
REQ-026 SHALL drive every output from a register; there is no combinational path from input to output.
REQ-027 SHALL never present an invalid BCD digit (A..F) on any nibble output.

Reset
REQ-028 SHALL, on reset assertion, asynchronously clear the prescaler, seconds, minutes and hours to 0, so that nibbleA..D=0, secondPulse=0 and colon=0.
REQ-029 SHALL, when reset is asserted in the middle of a second or during an increment pulse, discard that pending second or pulse.
REQ-030 SHALL start counting again on the first rising edge after reset deasserts, with the first secondPulse TICKS_PER_SECOND cycles later.

Structure
REQ-031 SHALL place the constants SECONDS_MAX=59, MINUTES_MAX=59, HOURS_MAX=23 and the BCD digit width in the shared package time_pkg.
REQ-032 SHALL implement minutes and hours with one reusable sub-module bcd_modulo_counter, with inputs increment and maximum and outputs tens, ones and carry, instantiated twice.
REQ-033 SHALL connect nibbleA..D directly to the nibble inputs of the downstream seven-segment display stage.

Verification
REQ-034 SHALL check: reset, then TICKS_PER_SECOND=4 with run=1 for 240 cycles -> nibbleA..D = 0,0,0,1 and 60 secondPulses.
REQ-035 SHALL check: preload 23:59:59 with the prescaler at 3, then one edge -> nibbleA..D = 0,0,0,0 and secondPulse=1.
REQ-036 SHALL check: 14:59, then incrementMinute -> 14:00, seconds 0, hours unchanged.
REQ-037 SHALL check: 23:xx, then incrementHour -> 00:xx, and incrementHour on the same cycle as a 12:59:59 tick -> 13:00.
REQ-038 SHALL check: run=0 for 100 cycles -> no secondPulse and all outputs constant; incrementHour still advances hours.
REQ-039 SHALL check: reset asserted mid-second at 10:30 -> all outputs 0 in the same cycle, with no clock edge needed.
